// File: rtl/four_input_debounce_if.sv
// Switch-conditioning bus: raw levels in, debounced levels, edge pulses and busy flags out.
interface four_input_debounce_if #(
  parameter int NUM_LANES = 4
);
  logic [NUM_LANES-1:0] sw_in;
  logic [NUM_LANES-1:0] sw_out;
  logic [NUM_LANES-1:0] rise;
  logic [NUM_LANES-1:0] fall;
  logic [NUM_LANES-1:0] busy;

  modport master (output sw_in, input sw_out, rise, fall, busy);
  modport slave  (input sw_in, output sw_out, rise, fall, busy);
endinterface

// File: rtl/four_input_debounce.sv
// Four-channel synchronise + debounce stage feeding the A..D inputs of the AND chain.
// Each lane is an independent 2-flop synchroniser and a counting FSM.
module debounce_lane #(
  parameter int DB_COUNT = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_out,
  output logic rise,
  output logic fall,
  output logic busy
);
  typedef enum logic [1:0] {LOW, RISING, HIGH, FALLING} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s1, s2;
  logic             sw_d, rise_d, fall_d, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      state  <= LOW;
      cnt    <= '0;
      sw_out <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      s1     <= sw_raw;
      s2     <= s1;
      state  <= nxt;
      cnt    <= cnt_nxt;
      sw_out <= sw_d;
      rise   <= rise_d;
      fall   <= fall_d;
      busy   <= busy_d;
    end
  end

  // cnt only advances below LAST, so it can never wrap.
  always_comb begin
    nxt     = state;
    cnt_nxt = '0;
    case (state)
      LOW:
        if (s2) begin
          if (DB_COUNT == 1) nxt = HIGH;
          else begin
            nxt     = RISING;
            cnt_nxt = ONE;
          end
        end
      RISING:
        if (!s2)              nxt = LOW;
        else if (cnt == LAST) nxt = HIGH;
        else                  cnt_nxt = cnt + ONE;
      HIGH:
        if (!s2) begin
          if (DB_COUNT == 1) nxt = LOW;
          else begin
            nxt     = FALLING;
            cnt_nxt = ONE;
          end
        end
      FALLING:
        if (s2)               nxt = HIGH;
        else if (cnt == LAST) nxt = LOW;
        else                  cnt_nxt = cnt + ONE;
      default: nxt = LOW;
    endcase
  end

  // Outputs are decoded from the upcoming state so they land in the same edge as the FSM.
  always_comb begin
    sw_d   = (nxt == HIGH) || (nxt == FALLING);
    busy_d = (nxt == RISING) || (nxt == FALLING);
    rise_d = (nxt == HIGH) && ((state == LOW) || (state == RISING));
    fall_d = (nxt == LOW) && ((state == HIGH) || (state == FALLING));
  end
endmodule

module four_input_debounce #(
  parameter int DB_COUNT = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  four_input_debounce_if.slave bus
);
  localparam int NUM_LANES = 4;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    debounce_lane #(.DB_COUNT(DB_COUNT), .CNT_W(CNT_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_raw (bus.sw_in[i]),
      .sw_out (bus.sw_out[i]),
      .rise   (bus.rise[i]),
      .fall   (bus.fall[i]),
      .busy   (bus.busy[i])
    );
  end
endmodule

// File: tb/tb_four_input_debounce.sv
// Directed bench: stimulus queues expected edge events, a negedge monitor pops and checks them.
module tb_four_input_debounce;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  four_input_debounce_if bus ();

  four_input_debounce #(.DB_COUNT(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] sw;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Any edge pulse must match the head of the queue in cycle and content.
  always @(negedge clk) begin
    if (rst_n && (bus.rise != 4'b0 || bus.fall != 4'b0)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {bus.rise, bus.fall}, 8'h00);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_rise", bus.rise, e.rise);
        chk("ev_fall", bus.fall, e.fall);
        chk("ev_sw_out", bus.sw_out, e.sw);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected pulse 17 edges after the first sampling edge (cyc+1).
  task automatic push_ev(input logic [3:0] r, input logic [3:0] f, input logic [3:0] s);
    ev_t e;
    e.cyc = cyc + 18; e.rise = r; e.fall = f; e.sw = s;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    step(2);
  endtask

  task automatic at_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  initial begin
    int c;
    bus.sw_in = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sw_out", bus.sw_out, 4'b0);
    chk("rst_rise", bus.rise, 4'b0);
    chk("rst_fall", bus.fall, 4'b0);
    chk("rst_busy", bus.busy, 4'b0);
    step(3);
    rst_n = 1'b1;

    // Quiet inputs: nothing moves.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("quiet_sw_out", bus.sw_out, 4'b0);
      chk("quiet_flags", {bus.rise, bus.fall, bus.busy}, 12'h0);
    end
    step(1);

    // Single channel rise with busy timing.
    c = cyc;
    bus.sw_in = 4'b0001;
    push_ev(4'b0001, 4'b0000, 4'b0001);
    at_neg(c + 2);
    chk("busy0_k1", bus.busy, 4'b0000);
    at_neg(c + 3);
    chk("busy0_k2", bus.busy, 4'b0001);
    at_neg(c + 17);
    chk("busy0_k16", bus.busy, 4'b0001);
    drain();
    chk("busy0_done", bus.busy, 4'b0000);

    // Glitch on channel 2 shorter than the debounce window.
    bus.sw_in[2] = 1'b1;
    step(8);
    chk("glitch_busy", bus.busy[2], 1'b1);
    step(2);
    bus.sw_in[2] = 1'b0;
    step(20);
    chk("glitch_sw_out", bus.sw_out, 4'b0001);
    chk("glitch_busy_clr", bus.busy, 4'b0000);

    // Channel 0 back low, then all four together, then channel 3 falls.
    bus.sw_in = 4'b0000;
    push_ev(4'b0000, 4'b0001, 4'b0000);
    drain();
    bus.sw_in = 4'b1111;
    push_ev(4'b1111, 4'b0000, 4'b1111);
    drain();
    bus.sw_in[3] = 1'b0;
    push_ev(4'b0000, 4'b1000, 4'b0111);
    drain();
    bus.sw_in = 4'b0000;
    push_ev(4'b0000, 4'b0111, 4'b0000);
    drain();

    // Bounce on channel 1: 5-cycle segments never qualify, final hold does.
    for (int i = 0; i < 12; i++) begin
      bus.sw_in[1] = (i % 2 == 0);
      step(5);
    end
    chk("bounce_sw_out", bus.sw_out, 4'b0000);
    bus.sw_in[1] = 1'b1;
    push_ev(4'b0010, 4'b0000, 4'b0010);
    drain();
    bus.sw_in[1] = 1'b0;
    push_ev(4'b0000, 4'b0010, 4'b0000);
    drain();

    // Async reset mid-count aborts channel 0, which then restarts from scratch.
    bus.sw_in[0] = 1'b1;
    step(8);
    chk("pre_rst_busy", bus.busy, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", bus.busy, 4'b0000);
    chk("async_rst_sw_out", bus.sw_out, 4'b0000);
    #2 rst_n = 1'b1;
    push_ev(4'b0001, 4'b0000, 4'b0001);
    drain();
    chk("final_sw_out", bus.sw_out, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
